// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. It issues one word-aligned request at a time to
// instruction memory and buffers the returned words, tagged with their PC, in a
// 2-entry FIFO whose head drives the decode interface straight from registers.
// A taken branch (redirect) flushes the FIFO and retargets fetching. If a
// request is still in flight, its data is waited for and then dropped.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   imem_req     out  request valid (held with imem_addr until imem_ack)
//   imem_addr    out  word-aligned fetch address
//   imem_ack     in   data for the current request is on imem_rdata this cycle
//   imem_rdata   in   fetched instruction word
//   redirect     in   taken branch; overrides push and pop in the same cycle
//   redirect_pc  in   branch target (low two bits ignored)
//   instr        out  instruction at the FIFO head
//   instr_pc     out  address of instr
//   instr_valid  out  instr/instr_pc are valid
//   instr_ready  in   decode accepts instr this cycle
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

    typedef enum logic [1:0] {
        S_FETCH,    // request issuing or outstanding
        S_FULL,     // FIFO holds two words, no request
        S_DISCARD   // waiting for the ack of a request made stale by a redirect
    } state_e;

    state_e                  state_q,    state_d;
    logic [1:0]              count_q,    count_d;
    logic [DATA_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic                    req_q,      req_d;
    logic [DATA_WIDTH-1:0]   addr_q,     addr_d;
    // FIFO head (drives the decode interface) and second entry
    logic [DATA_WIDTH-1:0]   head_instr_q, head_instr_d;
    logic [DATA_WIDTH-1:0]   head_pc_q,    head_pc_d;
    logic [DATA_WIDTH-1:0]   tail_instr_q, tail_instr_d;
    logic [DATA_WIDTH-1:0]   tail_pc_q,    tail_pc_d;
    logic                    valid_q,      valid_d;

    logic                    push;
    logic                    pop;
    logic [1:0]              wr_slot;
    logic [DATA_WIDTH-1:0]   target_pc;
    logic [DATA_WIDTH-1:0]   next_pc;

    // Targets are forced word-aligned, so the low bits never matter.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign target_pc = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    assign next_pc   = fetch_pc_q + DATA_WIDTH'(4);

    // Acks are only meaningful while our own request is in flight; this also
    // makes a stray ack straight after reset harmless.
    assign push    = (state_q != S_DISCARD) && req_q && imem_ack;
    assign pop     = valid_q && instr_ready;
    assign wr_slot = count_q - {1'b0, pop};

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        count_d      = count_q;
        fetch_pc_d   = fetch_pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;

        if (redirect) begin
            count_d    = 2'd0;
            fetch_pc_d = target_pc;
            if (req_q && !imem_ack) begin
                // Memory still owes us a word: keep the old request stable
                // until it is acked, remembering only the newest target.
                state_d = S_DISCARD;
            end else begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                addr_d  = target_pc;
            end
        end else if (state_q == S_DISCARD) begin
            if (imem_ack) begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                addr_d  = fetch_pc_q;
            end
        end else begin
            // Shift on pop first, then write into the first free slot.
            if (pop) begin
                head_instr_d = tail_instr_q;
                head_pc_d    = tail_pc_q;
            end
            if (push) begin
                fetch_pc_d = next_pc;
                if (wr_slot == 2'd0) begin
                    head_instr_d = imem_rdata;
                    head_pc_d    = addr_q;
                end else begin
                    tail_instr_d = imem_rdata;
                    tail_pc_d    = addr_q;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            // Only request when at most one slot is in use, so the word coming
            // back always has a free slot whatever decode does meanwhile.
            req_d   = (count_d < 2'd2);
            addr_d  = push ? next_pc : fetch_pc_q;
            state_d = (count_d == 2'd2) ? S_FULL : S_FETCH;
        end

        valid_d = (count_d != 2'd0);
    end

    // NOTE: the FIFO storage is reset along with the control state because the
    // head registers drive instr/instr_pc directly and must read zero in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            count_q      <= 2'd0;
            fetch_pc_q   <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            tail_instr_q <= '0;
            tail_pc_q    <= '0;
            valid_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            count_q      <= count_d;
            fetch_pc_q   <= fetch_pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = head_instr_q;
    assign instr_pc    = head_pc_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed stimulus drives the memory and redirect side; every word expected at
// the decode interface is pushed into a scoreboard queue when its ack is
// issued. A separate monitor pops and compares on each decode handshake, and
// flushes the queue whenever the design is told to flush (redirect or reset).
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int unsigned DW       = 32;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] JUNK     = 32'hBAD0_BAD0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          imem_req;
    logic [DW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          redirect;
    logic [DW-1:0] redirect_pc;
    logic [DW-1:0] instr;
    logic [DW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_for(input logic [31:0] addr);
        return addr ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect a request at addr, ack it with its word and expect that word at decode.
    task automatic ack_word(input logic [31:0] addr);
        check("req_before_ack", {31'd0, imem_req}, 32'd1);
        check("addr_before_ack", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = word_for(addr);
        exp_q.push_back('{pc: addr, word: word_for(addr)});
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    // Ack with data that must never reach decode.
    task automatic ack_junk();
        imem_ack   = 1'b1;
        imem_rdata = JUNK;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n || redirect) begin
            exp_q.delete();
        end else if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h instr %h, expected nothing (t=%0t)",
                         instr_pc, instr, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc", instr_pc, e.pc);
                check("sb_instr", instr, e.word);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;

        // Reset values
        step();
        step();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        rst_n = 1'b1;
        step();
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RST_PC);

        // Zero-wait streaming, decode always ready
        for (int i = 0; i < 4; i++) begin
            ack_word(32'(i * 4));
            check("stream_valid", {31'd0, instr_valid}, 32'd1);
        end
        check("stream_addr_held", imem_addr, 32'h10);
        step();
        check("stream_drained", {31'd0, instr_valid}, 32'd0);

        // Decode stalled: fill to FULL, single pop, request resumes
        instr_ready = 1'b0;
        ack_word(32'h10);
        ack_word(32'h14);
        check("full_req", {31'd0, imem_req}, 32'd0);
        check("full_head_pc", instr_pc, 32'h10);
        step();
        check("full_req_hold", {31'd0, imem_req}, 32'd0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("after_pop_req", {31'd0, imem_req}, 32'd1);
        check("after_pop_addr", imem_addr, 32'h18);
        check("after_pop_head", instr_pc, 32'h14);
        instr_ready = 1'b1;
        step();

        // Delayed ack with redirect in the first wait cycle
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect    = 1'b0;
        check("disc_addr_w1", imem_addr, 32'h18);
        check("disc_req_w1", {31'd0, imem_req}, 32'd1);
        step();
        check("disc_addr_w2", imem_addr, 32'h18);
        ack_junk();
        step();
        imem_ack = 1'b0;
        check("disc_new_addr", imem_addr, 32'h40);
        check("disc_valid", {31'd0, instr_valid}, 32'd0);
        step();
        check("disc_dropped", {31'd0, instr_valid}, 32'd0);

        // Multiple redirects while discarding: the last one wins
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect_pc = 32'h60;
        step();
        redirect    = 1'b0;
        check("lastwins_hold", imem_addr, 32'h40);
        ack_junk();
        step();
        imem_ack = 1'b0;
        ack_word(32'h60);
        check("lastwins_valid", {31'd0, instr_valid}, 32'd1);
        step();

        // Redirect in the same cycle as ack, unaligned target
        ack_junk();
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        step();
        imem_ack = 1'b0;
        redirect = 1'b0;
        check("same_ack_addr", imem_addr, 32'h100);
        check("same_ack_valid", {31'd0, instr_valid}, 32'd0);

        // Redirect while FULL
        instr_ready = 1'b0;
        ack_word(32'h100);
        ack_word(32'h104);
        check("full2_req", {31'd0, imem_req}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        check("full_redir_req", {31'd0, imem_req}, 32'd1);
        check("full_redir_addr", imem_addr, 32'h300);
        check("full_redir_valid", {31'd0, instr_valid}, 32'd0);

        // Address wrap at the top of the space
        ack_junk();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        imem_ack = 1'b0;
        redirect = 1'b0;
        ack_word(32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        check("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);
        step();

        // Asynchronous reset with a full FIFO, then a late ack
        instr_ready = 1'b0;
        ack_word(32'h0);
        ack_word(32'h4);
        check("prerst_valid", {31'd0, instr_valid}, 32'd1);
        #2;
        imem_ack   = 1'b1;
        imem_rdata = JUNK;
        rst_n      = 1'b0;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_addr", imem_addr, RST_PC);
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_instr", instr, 32'd0);
        check("arst_instr_pc", instr_pc, 32'd0);
        step();
        step();
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("postrst_req", {31'd0, imem_req}, 32'd1);
        check("postrst_addr", imem_addr, RST_PC);
        check("postrst_valid", {31'd0, instr_valid}, 32'd0);
        step();
        check("late_ack_ignored", {31'd0, instr_valid}, 32'd0);
        check("postrst_addr_hold", imem_addr, RST_PC);

        step();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
